// File: rtl/tone_envelope.sv
// tone_envelope
// ADSR amplitude envelope that gates a 1-bit square-wave tone with a
// volume PWM derived from the current envelope level.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   tone_i      square-wave tone from the PWM modulator
//   note_on_i   single-cycle note trigger (retriggers ATTACK from any state)
//   note_off_i  single-cycle note release (ATTACK/DECAY/SUSTAIN -> RELEASE)
//   level_o     current envelope level (registered)
//   state_o     envelope state: IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   sound_o     gated audio bit, registered: tone_i & (vol_cnt < level)
module tone_envelope #(
    parameter int                LVL_BW      = 8,
    parameter logic [23:0]       TICK_DIV    = 24'd4800,
    parameter logic [LVL_BW-1:0] ATTACK_INC  = 8'd16,
    parameter logic [LVL_BW-1:0] DECAY_DEC   = 8'd4,
    parameter logic [LVL_BW-1:0] SUSTAIN_LVL = 8'd128,
    parameter logic [LVL_BW-1:0] RELEASE_DEC = 8'd8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tone_i,
    input  logic              note_on_i,
    input  logic              note_off_i,
    output logic [LVL_BW-1:0] level_o,
    output logic [2:0]        state_o,
    output logic              sound_o
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // Full-scale level widened by one bit so saturation can be detected.
    localparam logic [LVL_BW:0] LVL_MAX = {1'b0, {LVL_BW{1'b1}}};

    logic [23:0]       tick_cnt_q, tick_cnt_d;
    logic [LVL_BW-1:0] vol_cnt_q, vol_cnt_d;
    logic [LVL_BW-1:0] level_q, level_d;
    logic [2:0]        state_q, state_d;
    logic              sound_q, sound_d;

    logic              tick_s;
    logic              releasable_s;
    logic [LVL_BW:0]   att_sum_s;
    logic [LVL_BW:0]   dec_diff_s;
    logic [LVL_BW:0]   rel_diff_s;

    // Envelope tick divider; a note-on realigns it so the first tick lands
    // exactly TICK_DIV cycles after the trigger.
    always_comb begin
        tick_s = (tick_cnt_q == (TICK_DIV - 24'd1));
        if (note_on_i) begin
            tick_cnt_d = 24'd0;
        end else if (tick_s) begin
            tick_cnt_d = 24'd0;
        end else begin
            tick_cnt_d = tick_cnt_q + 24'd1;
        end
    end

    // Free-running volume PWM ramp; wraps naturally at 2^LVL_BW.
    always_comb begin
        vol_cnt_d = vol_cnt_q + LVL_BW'(1);
    end

    // Envelope FSM and level update. Arithmetic is one bit wider than the
    // level so that attack overflow and decay/release underflow show up in
    // the top bit and can be clamped.
    always_comb begin
        att_sum_s    = {1'b0, level_q} + {1'b0, ATTACK_INC};
        dec_diff_s   = {1'b0, level_q} - {1'b0, DECAY_DEC};
        rel_diff_s   = {1'b0, level_q} - {1'b0, RELEASE_DEC};
        releasable_s = (state_q == ST_ATTACK) || (state_q == ST_DECAY) ||
                       (state_q == ST_SUSTAIN);
        state_d      = state_q;
        level_d      = level_q;

        if (note_on_i) begin
            // Retrigger keeps the level: attack resumes from where it is.
            state_d = ST_ATTACK;
        end else if (note_off_i && releasable_s) begin
            state_d = ST_RELEASE;
        end else if (tick_s) begin
            case (state_q)
                ST_IDLE: begin
                    level_d = '0;
                end
                ST_ATTACK: begin
                    if (att_sum_s >= LVL_MAX) begin
                        level_d = '1;
                        state_d = ST_DECAY;
                    end else begin
                        level_d = att_sum_s[LVL_BW-1:0];
                    end
                end
                ST_DECAY: begin
                    // A sustain level at full scale makes this exit on the
                    // first tick with the level still at full scale.
                    if (dec_diff_s[LVL_BW] || (dec_diff_s[LVL_BW-1:0] <= SUSTAIN_LVL)) begin
                        level_d = SUSTAIN_LVL;
                        state_d = ST_SUSTAIN;
                    end else begin
                        level_d = dec_diff_s[LVL_BW-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    level_d = level_q;
                end
                ST_RELEASE: begin
                    if (rel_diff_s[LVL_BW] || (rel_diff_s[LVL_BW-1:0] == '0)) begin
                        level_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        level_d = rel_diff_s[LVL_BW-1:0];
                    end
                end
                default: begin
                    level_d = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
            level_d = level_q;
        end
    end

    // Audio gate: tone passes while the PWM ramp is below the level.
    always_comb begin
        sound_d = tone_i & (vol_cnt_q < level_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt_q <= 24'd0;
            vol_cnt_q  <= '0;
            level_q    <= '0;
            state_q    <= ST_IDLE;
            sound_q    <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            vol_cnt_q  <= vol_cnt_d;
            level_q    <= level_d;
            state_q    <= state_d;
            sound_q    <= sound_d;
        end
    end

    assign level_o = level_q;
    assign state_o = state_q;
    assign sound_o = sound_q;

endmodule

// File: tb/tb_tone_envelope.sv
// Bench for tone_envelope: two instances (sustain 128 and 64) share the same
// stimulus; a cycle-level behavioural model of the envelope is compared on
// every clock, plus directed checks of the key timing points.
module tb_tone_envelope;

    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       tone_i = 1'b0;
    logic       note_on_i = 1'b0;
    logic       note_off_i = 1'b0;
    logic [7:0] level_a, level_b;
    logic [2:0] state_a, state_b;
    logic       sound_a, sound_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: shared tick/volume counters, per-instance envelope.
    int m_cnt = 0;
    int m_vol = 0;
    int m_st[2]  = '{0, 0};
    int m_lvl[2] = '{0, 0};
    int m_snd[2] = '{0, 0};
    int sus[2]   = '{128, 64};

    int n, hi_a, hi_b, got;

    always #5 clk = ~clk;

    tone_envelope #(.TICK_DIV(24'd4), .SUSTAIN_LVL(8'd128)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .tone_i(tone_i), .note_on_i(note_on_i),
        .note_off_i(note_off_i), .level_o(level_a), .state_o(state_a), .sound_o(sound_a)
    );

    tone_envelope #(.TICK_DIV(24'd4), .SUSTAIN_LVL(8'd64)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .tone_i(tone_i), .note_on_i(note_on_i),
        .note_off_i(note_off_i), .level_o(level_b), .state_o(state_b), .sound_o(sound_b)
    );

    task automatic check_value(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Envelope rules: triggers first, then tick-driven saturating arithmetic.
    task automatic env_next(input int st, input int lvl, input bit tick, input bit on,
                            input bit off, input int s, output int nst, output int nlvl);
        nst  = st;
        nlvl = lvl;
        if (on) begin
            nst = 1;
        end else if (off && st >= 1 && st <= 3) begin
            nst = 4;
        end else if (tick) begin
            if (st == 1) begin
                nlvl = (lvl + 16 > 255) ? 255 : lvl + 16;
                if (nlvl == 255) nst = 2;
            end else if (st == 2) begin
                nlvl = (lvl - 4 < s) ? s : lvl - 4;
                if (nlvl == s) nst = 3;
            end else if (st == 4) begin
                nlvl = (lvl - 8 < 0) ? 0 : lvl - 8;
                if (nlvl == 0) nst = 0;
            end else if (st == 0) begin
                nlvl = 0;
            end
        end
    endtask

    // One clock: advance the model with the inputs being sampled, then compare.
    task automatic step();
        int nst, nlvl;
        bit tick;
        @(posedge clk);
        if (rst_i) begin
            m_cnt = 0;
            m_vol = 0;
            for (int i = 0; i < 2; i++) begin
                m_st[i] = 0; m_lvl[i] = 0; m_snd[i] = 0;
            end
        end else begin
            tick = (m_cnt == TDIV - 1);
            for (int i = 0; i < 2; i++) begin
                m_snd[i] = (tone_i && (m_vol < m_lvl[i])) ? 1 : 0;
                env_next(m_st[i], m_lvl[i], tick, note_on_i, note_off_i, sus[i], nst, nlvl);
                m_st[i]  = nst;
                m_lvl[i] = nlvl;
            end
            m_cnt = (note_on_i || tick) ? 0 : m_cnt + 1;
            m_vol = (m_vol + 1) % 256;
        end
        #1;
        check_value("a_level", int'(level_a), m_lvl[0]);
        check_value("a_state", int'(state_a), m_st[0]);
        check_value("a_sound", int'(sound_a), m_snd[0]);
        check_value("b_level", int'(level_b), m_lvl[1]);
        check_value("b_state", int'(state_b), m_st[1]);
        check_value("b_sound", int'(sound_b), m_snd[1]);
    endtask

    task automatic pulse(input bit on, input bit off);
        note_on_i  = on;
        note_off_i = off;
        step();
        note_on_i  = 1'b0;
        note_off_i = 1'b0;
    endtask

    initial begin
        // Reset with triggers toggling.
        rst_i = 1'b1; note_on_i = 1'b1; note_off_i = 1'b0;
        step();
        note_on_i = 1'b0; note_off_i = 1'b1;
        step();
        rst_i = 1'b0; note_off_i = 1'b0;
        check_value("rst_level", int'(level_a), 0);
        check_value("rst_state", int'(state_a), 0);
        check_value("rst_sound", int'(sound_a), 0);

        // Attack.
        pulse(1'b1, 1'b0);
        check_value("attack_state", int'(state_a), 1);
        for (int i = 0; i < 4; i++) step();
        check_value("attack_first_tick", int'(level_a), 16);
        n = 4;
        while (state_a != 3'd2 && n < 200) begin step(); n++; end
        check_value("attack_cycles", n, 64);
        check_value("attack_peak", int'(level_a), 255);

        // Decay to sustain 128.
        n = 0;
        while (state_a != 3'd3 && n < 300) begin step(); n++; end
        check_value("decay_cycles", n, 128);
        check_value("decay_sustain", int'(level_a), 128);
        for (int i = 0; i < 100; i++) step();
        check_value("sustain_hold", int'(level_a), 128);
        check_value("sustain_b", int'(level_b), 64);

        // Gate: count sound highs over one full PWM period.
        tone_i = 1'b1;
        hi_a = 0; hi_b = 0;
        for (int i = 0; i < 256; i++) begin step(); hi_a += int'(sound_a); hi_b += int'(sound_b); end
        check_value("gate_a_128", hi_a, 128);
        check_value("gate_b_64", hi_b, 64);
        tone_i = 1'b0;
        hi_a = 0; hi_b = 0;
        for (int i = 0; i < 256; i++) begin step(); hi_a += int'(sound_a); hi_b += int'(sound_b); end
        check_value("gate_tone0_a", hi_a, 0);
        check_value("gate_tone0_b", hi_b, 0);

        // Release to idle.
        pulse(1'b0, 1'b1);
        check_value("release_state", int'(state_a), 4);
        n = 0;
        while (state_a != 3'd0 && n < 300) begin step(); n++; end
        got = (n >= 61 && n <= 64) ? 1 : 0;
        check_value("release_cycles_ok", got, 1);
        check_value("release_level", int'(level_a), 0);

        // Retrigger at release level 64 with simultaneous on/off.
        pulse(1'b1, 1'b0);
        n = 0;
        while (level_a != 8'd128 && n < 100) begin step(); n++; end
        check_value("retrig_reach_128", int'(level_a), 128);
        pulse(1'b0, 1'b1);
        n = 0;
        while (level_a != 8'd64 && n < 100) begin step(); n++; end
        check_value("retrig_reach_64", int'(level_a), 64);
        pulse(1'b1, 1'b1);
        check_value("retrig_state", int'(state_a), 1);
        for (int i = 0; i < 3; i++) step();
        check_value("retrig_hold", int'(level_a), 64);
        step();
        check_value("retrig_resume", int'(level_a), 80);
        pulse(1'b0, 1'b1);
        n = 0;
        while (state_a != 3'd0 && n < 300) begin step(); n++; end
        check_value("retrig_idle", int'(state_a), 0);
        pulse(1'b0, 1'b1);
        check_value("off_in_idle_state", int'(state_a), 0);
        check_value("off_in_idle_level", int'(level_a), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            note_on_i  = ($urandom_range(0, 63) == 0);
            note_off_i = ($urandom_range(0, 47) == 0);
            tone_i     = $urandom_range(0, 1) == 1;
            rst_i      = ($urandom_range(0, 999) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
